// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its result queue.
package wb_pkg;
    localparam int NUM_IN = 3;
    localparam int NUM_WB = 2;
    localparam int ALU0   = 0;
    localparam int ALU1   = 1;
    localparam int MEM    = 2;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PREG_W = 6;
    localparam int DEF_ROB_W  = 6;
    localparam int DEF_PC_W   = 12;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] res;
        logic [DEF_PREG_W-1:0] rd;
        logic [DEF_ROB_W-1:0]  rob;
        logic [DEF_PC_W-1:0]   pc;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// Circular result queue: up to three pushes at the tail, two peeks at the head,
// zero to two pops per cycle. count tells full apart from empty.
module wb_queue
    import wb_pkg::*;
#(
    parameter int  QDEPTH  = 8,
    parameter type entry_t = wb_entry_t,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = $clog2(QDEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                pop_n,
    input  logic [1:0]                push_n,
    input  entry_t [NUM_IN-1:0]       push_data,
    output entry_t [NUM_WB-1:0]       peek,
    output logic [CW-1:0]             count
);
    entry_t          mem [QDEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    // Pointer arithmetic is PW bits wide, so tail+i wraps for free.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (!rst && !flush && (2'(i) < push_n))
                mem[tail + PW'(i)] <= push_data[i];
        end
    end

    assign peek[0] = mem[head];
    assign peek[1] = mem[head + PW'(1)];
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges queued and newly arriving results in age order onto
// two registered writeback ports, queues the rest, and raises a registered stall.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PREG_W = DEF_PREG_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int QDEPTH = 8,
    localparam int CW    = $clog2(QDEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_IN-1:0]          in_valid,
    input  logic [NUM_IN*DATA_W-1:0]   in_res,
    input  logic [NUM_IN*PREG_W-1:0]   in_rd,
    input  logic [NUM_IN*ROB_W-1:0]    in_rob,
    input  logic [NUM_IN*PC_W-1:0]     in_pc,
    output logic [NUM_WB-1:0]          wb_valid,
    output logic [NUM_WB-1:0]          wb_we,
    output logic [NUM_WB*DATA_W-1:0]   wb_data,
    output logic [NUM_WB*PREG_W-1:0]   wb_rd,
    output logic [NUM_WB*ROB_W-1:0]    wb_rob,
    output logic [NUM_WB*PC_W-1:0]     wb_pc,
    output logic                       stall,
    output logic [CW-1:0]              q_count,
    output logic                       err_overflow
);
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [PREG_W-1:0] rd;
        logic [ROB_W-1:0]  rob;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t [NUM_IN-1:0] lane, arr, push_data;
    entry_t [NUM_WB-1:0] peek, wb_next, wb_q;
    logic   [NUM_IN-1:0] acc;
    logic   [NUM_WB-1:0] v_next, we_next;
    logic   [1:0]        n_arr, q_take, a_take, push_n;
    logic   [CW-1:0]     count, count_next;
    logic                violation;

    // Issuing while stalled is a protocol violation: drop the whole cycle's arrivals.
    assign violation = |in_valid && stall;
    assign acc       = violation ? '0 : in_valid;

    always_comb begin
        lane  = '0;
        arr   = '0;
        n_arr = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            lane[i].res = in_res[i*DATA_W +: DATA_W];
            lane[i].rd  = in_rd[i*PREG_W +: PREG_W];
            lane[i].rob = in_rob[i*ROB_W +: ROB_W];
            lane[i].pc  = in_pc[i*PC_W +: PC_W];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (acc[i]) begin
                arr[n_arr] = lane[i];
                n_arr      = n_arr + 2'd1;
            end
        end
    end

    // Queue entries are older than arrivals, so they take the ports first.
    always_comb begin
        q_take  = (count >= CW'(2)) ? 2'd2 : 2'(count);
        a_take  = (n_arr < (2'd2 - q_take)) ? n_arr : (2'd2 - q_take);
        wb_next = '0;
        v_next  = '0;
        we_next = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (2'(p) < q_take)
                wb_next[p] = peek[p];
            else
                wb_next[p] = arr[2'(p) - q_take];
            v_next[p]  = 2'(p) < (q_take + a_take);
            we_next[p] = v_next[p] && (wb_next[p].rd != '0);
        end
        push_n     = n_arr - a_take;
        push_data  = arr >> ($bits(entry_t) * a_take);
        count_next = count + CW'(n_arr) - CW'(q_take) - CW'(a_take);
    end

    wb_queue #(
        .QDEPTH  (QDEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .pop_n     (q_take),
        .push_n    (push_n),
        .push_data (push_data),
        .peek      (peek),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= '0;
            wb_we        <= '0;
            wb_q         <= '0;
            stall        <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (violation)
                err_overflow <= 1'b1;
            if (flush) begin
                wb_valid <= '0;
                wb_we    <= '0;
                stall    <= 1'b0;
            end else begin
                wb_valid <= v_next;
                wb_we    <= we_next;
                stall    <= count_next >= CW'(QDEPTH - 1);
                for (int p = 0; p < NUM_WB; p++)
                    if (v_next[p])
                        wb_q[p] <= wb_next[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            wb_data[p*DATA_W +: DATA_W] = wb_q[p].res;
            wb_rd[p*PREG_W +: PREG_W]   = wb_q[p].rd;
            wb_rob[p*ROB_W +: ROB_W]    = wb_q[p].rob;
            wb_pc[p*PC_W +: PC_W]       = wb_q[p].pc;
        end
    end

    assign q_count = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based age-order model.
module tb_wb_arbiter;
    localparam int QDEPTH = 8;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  rd;
        logic [5:0]  rob;
        logic [11:0] pc;
    } tb_ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  in_valid = '0;
    logic [95:0] in_res = '0;
    logic [17:0] in_rd = '0;
    logic [17:0] in_rob = '0;
    logic [35:0] in_pc = '0;
    logic [1:0]  wb_valid, wb_we;
    logic [63:0] wb_data;
    logic [11:0] wb_rd, wb_rob;
    logic [23:0] wb_pc;
    logic        stall;
    logic [3:0]  q_count;
    logic        err_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    tb_ent_t mq[$];
    tb_ent_t m_wb[2];
    logic [1:0] m_v = '0, m_we = '0;
    logic       m_stall = 1'b0, m_err = 1'b0;

    wb_arbiter #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_res(in_res), .in_rd(in_rd), .in_rob(in_rob), .in_pc(in_pc),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_rob(wb_rob), .wb_pc(wb_pc), .stall(stall), .q_count(q_count),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic tb_ent_t lane_ent(input int i);
        tb_ent_t e;
        e.res = in_res[i*32 +: 32];
        e.rd  = in_rd[i*6 +: 6];
        e.rob = in_rob[i*6 +: 6];
        e.pc  = in_pc[i*12 +: 12];
        return e;
    endfunction

    task automatic set_lane(input int i, input logic [31:0] res, input logic [5:0] rd,
                            input logic [5:0] rob, input logic [11:0] pc);
        in_res[i*32 +: 32] = res;
        in_rd[i*6 +: 6]    = rd;
        in_rob[i*6 +: 6]   = rob;
        in_pc[i*12 +: 12]  = pc;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 3; i++)
            set_lane(i, $urandom, ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom),
                     6'($urandom), 12'($urandom));
    endtask

    // Reference: candidates = queue ++ arrivals in lane order; oldest two go out.
    task automatic model_edge();
        tb_ent_t c[$];
        if (rst) begin
            mq.delete();
            m_v = '0; m_we = '0; m_stall = 1'b0; m_err = 1'b0;
        end else begin
            if (m_stall && in_valid != 0) m_err = 1'b1;
            if (flush) begin
                mq.delete();
                m_v = '0; m_we = '0; m_stall = 1'b0;
            end else begin
                c = mq;
                if (!(m_stall && in_valid != 0))
                    for (int i = 0; i < 3; i++)
                        if (in_valid[i]) c.push_back(lane_ent(i));
                for (int p = 0; p < 2; p++) begin
                    m_v[p] = 1'b0; m_we[p] = 1'b0;
                    if (c.size() > 0) begin
                        m_wb[p] = c.pop_front();
                        m_v[p]  = 1'b1;
                        m_we[p] = (m_wb[p].rd != 0);
                    end
                end
                mq = c;
                m_stall = (mq.size() >= QDEPTH - 1);
            end
        end
    endtask

    task automatic compare();
        chk("wb_valid", wb_valid, m_v);
        chk("wb_we", wb_we, m_we);
        chk("stall", stall, m_stall);
        chk("q_count", q_count, mq.size());
        chk("err_overflow", err_overflow, m_err);
        for (int p = 0; p < 2; p++) begin
            if (m_v[p]) begin
                chk("wb_data", wb_data[p*32 +: 32], m_wb[p].res);
                chk("wb_rd", wb_rd[p*6 +: 6], m_wb[p].rd);
                chk("wb_rob", wb_rob[p*6 +: 6], m_wb[p].rob);
                chk("wb_pc", wb_pc[p*12 +: 12], m_wb[p].pc);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        in_valid = '0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_wb_rd", wb_rd, 64'd0);
        chk("rst_wb_rob", wb_rob, 64'd0);
        chk("rst_wb_pc", wb_pc, 64'd0);

        // Single ALU0 result
        set_lane(0, 32'hDEADBEEF, 6'd5, 6'd3, 12'h100);
        in_valid = 3'b001;
        step();
        idle();
        chk("t1_valid", wb_valid, 2'b01);
        chk("t1_we", wb_we, 2'b01);
        chk("t1_rd", wb_rd[5:0], 6'd5);
        chk("t1_data", wb_data[31:0], 32'hDEADBEEF);
        chk("t1_qcount", q_count, 4'd0);
        step();

        // Three lanes at once
        set_lane(0, 32'h11, 6'd1, 6'd1, 12'h1);
        set_lane(1, 32'h22, 6'd2, 6'd2, 12'h2);
        set_lane(2, 32'h33, 6'd3, 6'd3, 12'h3);
        in_valid = 3'b111;
        step();
        idle();
        chk("t2_rob0", wb_rob[5:0], 6'd1);
        chk("t2_rob1", wb_rob[11:6], 6'd2);
        chk("t2_qcount", q_count, 4'd1);
        step();
        chk("t2_rob_late", wb_rob[5:0], 6'd3);
        chk("t2_valid_late", wb_valid, 2'b01);
        step();

        // Fill until stall, then drain
        for (int k = 0; k < 20 && !m_stall; k++) begin
            rand_lanes(); in_valid = 3'b111; step();
        end
        chk("t3_stall", stall, 1'b1);
        chk("t3_qcount", q_count, 4'(QDEPTH - 1));
        idle();
        for (int k = 0; k < 10; k++) step();
        chk("t3_drained", q_count, 4'd0);

        // Overflow violation, sticky through flush
        for (int k = 0; k < 20 && !m_stall; k++) begin
            rand_lanes(); in_valid = 3'b111; step();
        end
        rand_lanes(); in_valid = 3'b100;
        step();
        idle();
        chk("t4_err", err_overflow, 1'b1);
        flush = 1'b1;
        step();
        idle();
        chk("t4_err_after_flush", err_overflow, 1'b1);
        do_reset();
        chk("t4_err_after_rst", err_overflow, 1'b0);

        // Flush with count = 5 and two arrivals
        for (int k = 0; k < 5; k++) begin
            rand_lanes(); in_valid = 3'b111; step();
        end
        chk("t5_count5", q_count, 4'd5);
        rand_lanes(); in_valid = 3'b011; flush = 1'b1;
        step();
        idle();
        chk("t5_valid", wb_valid, 2'b00);
        chk("t5_qcount", q_count, 4'd0);
        chk("t5_stall", stall, 1'b0);
        rand_lanes(); in_valid = 3'b010;
        step();
        idle();
        chk("t5_after_valid", wb_valid, 2'b01);

        // rd = 0 store completion
        set_lane(2, 32'h5, 6'd0, 6'd9, 12'h9);
        in_valid = 3'b100;
        step();
        idle();
        chk("t6_valid0", wb_valid[0], 1'b1);
        chk("t6_we0", wb_we[0], 1'b0);
        chk("t6_rob0", wb_rob[5:0], 6'd9);

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            rand_lanes();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 29) == 0);
            if (m_stall)
                in_valid = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            else
                in_valid = $urandom_range(0, 1) ? 3'b111 : 3'($urandom_range(0, 7));
            step();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
